adder_seq_driver: RTL
=====================

Name: adder_seq_driver

Overview:
- Initiator for the team's sample/done 4-bit adder.
- Generates pseudo-random operand pairs and issues each with a one-cycle `sample` pulse.
- Waits for the adder's `done` handshake, captures the 5-bit sum and checks it against a locally computed `a+b`.
- Runs a programmed number of operations and reports mismatch/timeout counts.
- Sits beside the adder in the self-check harness; its outputs connect directly to the adder's `a`, `b`, `sample`, and its inputs to `s`, `done`.

Parameters:
- N_OPS, 16, operations per run (1..255).
- TIMEOUT, 8, max cycles per wait phase before declaring a timeout (2..255).
- SEED, 8'h5A, LFSR reload value at each start; must be nonzero (zero is replaced by 8'h01).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a run; sampled only in IDLE or FINISH.
- a  output  4  operand A to adder.
- b  output  4  operand B to adder.
- sample  output  1  one-cycle capture strobe to adder.
- s  input  5  sum from adder.
- done  input  1  adder result-valid level.
- busy  output  1  high from start acceptance until FINISH entered.
- finished  output  1  high in FINISH state.
- err_count  output  8  sum mismatches this run, saturating at 255.
- timeout_count  output  8  timed-out operations this run, saturating at 255.
- ops_done  output  8  operations completed (checked or timed out) this run.

Behaviour:
- Reset values (async, on rst_n=0): state=IDLE, a=0, b=0, sample=0, busy=0, finished=0, err_count=0, timeout_count=0, ops_done=0, lfsr=SEED.
- LFSR:
  - 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1; shifts left.
  - New bit 0 = b7^b5^b4^b3.
  - Advances exactly once per operation, on the ISSUE cycle.
- Operands: a=lfsr[3:0], b=lfsr[7:4], taken from the LFSR value before the advance. They are registered and held constant from ISSUE until the next ISSUE.
- Expected sum: exp = {1'b0,a}+{1'b0,b}, 5-bit, no truncation. It is held in a register.
- IDLE:
  - start=1 → clear counters, reload LFSR=SEED, busy=1, go to ISSUE.
- ISSUE:
  - Drive a/b from the LFSR; sample=1 for this cycle only.
  - Clear the wait timer; go to WAIT_LOW.
- WAIT_LOW:
  - Wait for done=0, which is the adder's acknowledgement of capture.
  - A stale done=1 from the previous operation is ignored.
  - done=0 → clear timer, go to WAIT_HIGH.
- WAIT_HIGH:
  - done=1 → register s, go to CHECK.
- Timeout:
  - In WAIT_LOW or WAIT_HIGH, the timer counts cycles in the state.
  - timer reaches TIMEOUT-1 without the exit condition → timeout_count+1, ops_done+1, go to NEXT.
- CHECK:
  - Captured s != exp → err_count+1.
  - ops_done+1; go to NEXT.
- NEXT:
  - ops_done==N_OPS → FINISH (busy=0, finished=1).
  - Otherwise → ISSUE.
- FINISH:
  - Counters hold.
  - start=1 → same as the IDLE start (finished=0, busy=1, counters cleared).
- Latency:
  - Nominal adder: ISSUE at cycle k, WAIT_LOW sees done=0 at k+1, WAIT_HIGH sees done=1 at k+2, CHECK at k+3, NEXT at k+4, next ISSUE at k+5.
  - One operation therefore takes 5 cycles.
- sample is never asserted outside ISSUE. Back-to-back samples are impossible.
- start while busy is ignored.
- Saturation: err_count and timeout_count stop at 255, with no wrap.
- Reset mid-run: immediate return to reset values. Any in-flight adder operation is abandoned, and its result is not checked.
- An s value arriving when not in WAIT_HIGH is ignored.

Test Plan:
- Reset, then start pulse with a correct adder, N_OPS=4 → sample pulses at 5-cycle spacing. First op a=4'hA, b=4'h5, exp=5'h0F. ops_done=4, err_count=0, timeout_count=0, finished=1.
- Adder model forces s=0 on every op, N_OPS=16 → err_count=16, timeout_count=0, finished=1.
- done held permanently 1 (adder never drops done) → each op times out in WAIT_LOW after TIMEOUT cycles. timeout_count=N_OPS, err_count=0.
- Adder delays done rise by 3 extra cycles (still under TIMEOUT=8) → no timeouts, err_count=0, op period 8 cycles.
- rst_n low for 1 cycle during WAIT_HIGH of op 3 → all outputs return to reset values asynchronously. A subsequent start reproduces the identical operand sequence from SEED.
- start asserted continuously through a run → ignored while busy, restart on the cycle FINISH is reached. Max operands a=4'hF, b=4'hF must check exp=5'h1E with no truncation.

Source files
------------

// File: rtl/adder_seq_driver_if.sv
// Handshake bundle between the sequence driver and the sample/done 4-bit adder.
// The driver owns operands and strobe; the adder owns the sum and result-valid level.
interface adder_seq_driver_if;
    logic [3:0] a;
    logic [3:0] b;
    logic       sample;
    logic [4:0] s;
    logic       done;

    modport master (output a, b, sample, input s, done);
    modport slave  (input a, b, sample, output s, done);
endinterface

// File: rtl/adder_seq_driver.sv
// Initiator that feeds LFSR operand pairs to the sample/done adder,
// checks each returned sum against a local a+b and tallies mismatches and timeouts.
module adder_seq_driver #(
    parameter int unsigned N_OPS   = 16,
    parameter int unsigned TIMEOUT = 8,
    parameter logic [7:0]  SEED    = 8'h5A
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    adder_seq_driver_if.master  add,
    output logic                busy,
    output logic                finished,
    output logic [7:0]          err_count,
    output logic [7:0]          timeout_count,
    output logic [7:0]          ops_done
);
    // A zero seed would lock the LFSR, so it is promoted to 1.
    localparam logic [7:0] SEED_NZ  = (SEED == 8'h00) ? 8'h01 : SEED;
    localparam logic [7:0] OPS_LAST = 8'(N_OPS);
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE, ISSUE, WAIT_LOW, WAIT_HIGH, CHECK, NEXT, FINISH
    } state_t;

    state_t     state;
    logic [7:0] lfsr;
    logic [7:0] timer;
    logic [4:0] exp_sum;
    logic [4:0] sum_cap;

    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Operands and strobe are loaded on the transition into ISSUE so that
    // sample is high exactly during the ISSUE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            lfsr          <= SEED_NZ;
            timer         <= 8'd0;
            add.a         <= 4'd0;
            add.b         <= 4'd0;
            add.sample    <= 1'b0;
            busy          <= 1'b0;
            finished      <= 1'b0;
            err_count     <= 8'd0;
            timeout_count <= 8'd0;
            ops_done      <= 8'd0;
        end else begin
            add.sample <= 1'b0;
            case (state)
                IDLE, FINISH: begin
                    if (start) begin
                        err_count     <= 8'd0;
                        timeout_count <= 8'd0;
                        ops_done      <= 8'd0;
                        add.a         <= SEED_NZ[3:0];
                        add.b         <= SEED_NZ[7:4];
                        lfsr          <= lfsr_step(SEED_NZ);
                        add.sample    <= 1'b1;
                        busy          <= 1'b1;
                        finished      <= 1'b0;
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    timer <= 8'd0;
                    state <= WAIT_LOW;
                end
                WAIT_LOW: begin
                    if (!add.done) begin
                        timer <= 8'd0;
                        state <= WAIT_HIGH;
                    end else if (timer == TMO_LAST) begin
                        timeout_count <= sat_inc(timeout_count);
                        ops_done      <= ops_done + 8'd1;
                        state         <= NEXT;
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end
                WAIT_HIGH: begin
                    if (add.done) begin
                        state <= CHECK;
                    end else if (timer == TMO_LAST) begin
                        timeout_count <= sat_inc(timeout_count);
                        ops_done      <= ops_done + 8'd1;
                        state         <= NEXT;
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end
                CHECK: begin
                    if (sum_cap != exp_sum) err_count <= sat_inc(err_count);
                    ops_done <= ops_done + 8'd1;
                    state    <= NEXT;
                end
                NEXT: begin
                    if (ops_done == OPS_LAST) begin
                        busy     <= 1'b0;
                        finished <= 1'b1;
                        state    <= FINISH;
                    end else begin
                        add.a      <= lfsr[3:0];
                        add.b      <= lfsr[7:4];
                        lfsr       <= lfsr_step(lfsr);
                        add.sample <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Data-only registers: expected sum and captured adder result.
    always_ff @(posedge clk) begin
        if (state == ISSUE) exp_sum <= {1'b0, add.a} + {1'b0, add.b};
        if (state == WAIT_HIGH && add.done) sum_cap <= add.s;
    end
endmodule
